// File: rtl/zap_page_walker_pkg.sv
// Shared MMU walker definitions: descriptor type codes, FSR status codes and
// TLB entry layouts (field order in each struct fixes the bit positions).
package zap_page_walker_pkg;

   localparam logic [1:0] L1_FAULT   = 2'b00;
   localparam logic [1:0] L1_COARSE  = 2'b01;
   localparam logic [1:0] L1_SECTION = 2'b10;
   localparam logic [1:0] L1_FINE    = 2'b11;

   localparam logic [1:0] L2_FAULT = 2'b00;
   localparam logic [1:0] L2_LARGE = 2'b01;
   localparam logic [1:0] L2_SMALL = 2'b10;
   localparam logic [1:0] L2_TINY  = 2'b11;

   localparam logic [3:0] FSR_SECT_TRANS = 4'b0101;
   localparam logic [3:0] FSR_PAGE_TRANS = 4'b0111;
   localparam logic [3:0] FSR_SECT_EXT   = 4'b1100;
   localparam logic [3:0] FSR_PAGE_EXT   = 4'b1110;

   typedef struct packed {
      logic [11:0] tag;
      logic [11:0] base;
      logic [1:0]  ap;
      logic [3:0]  dac;
      logic [1:0]  cb;
   } section_tlb_t;

   typedef struct packed {
      logic [19:0] tag;
      logic [19:0] base;
      logic [7:0]  ap;
      logic [3:0]  dac;
      logic [1:0]  cb;
   } spage_tlb_t;

   typedef struct packed {
      logic [15:0] tag;
      logic [15:0] base;
      logic [7:0]  ap;
      logic [3:0]  dac;
      logic [1:0]  cb;
   } lpage_tlb_t;

   typedef struct packed {
      logic [21:0] tag;
      logic [21:0] base;
      logic [1:0]  ap;
      logic [3:0]  dac;
      logic [1:0]  cb;
   } fpage_tlb_t;

   localparam int ZAP_SECTION_TLB_WDT = $bits(section_tlb_t);
   localparam int ZAP_SPAGE_TLB_WDT   = $bits(spage_tlb_t);
   localparam int ZAP_LPAGE_TLB_WDT   = $bits(lpage_tlb_t);
   localparam int ZAP_FPAGE_TLB_WDT   = $bits(fpage_tlb_t);

endpackage

// File: rtl/zap_walk_desc_decode.sv
// Combinational decode of an L1 or L2 descriptor: fault/next-level decision,
// L2 fetch address and packed TLB entries for every entry type.
module zap_walk_desc_decode
   import zap_page_walker_pkg::*;
(
   input  logic                           i_l2,
   input  logic                           i_fine_tbl,
   input  logic [31:0]                    i_desc,
   input  logic [31:0]                    i_va,
   input  logic [3:0]                     i_l1_dac,
   output logic                           o_fault,
   output logic [3:0]                     o_status,
   output logic [3:0]                     o_fault_dac,
   output logic                           o_go_l2,
   output logic                           o_l2_fine,
   output logic [31:0]                    o_l2_adr,
   output logic                           o_se,
   output logic                           o_sp,
   output logic                           o_lp,
   output logic                           o_fp,
   output logic [ZAP_SECTION_TLB_WDT-1:0] o_se_data,
   output logic [ZAP_SPAGE_TLB_WDT-1:0]   o_sp_data,
   output logic [ZAP_LPAGE_TLB_WDT-1:0]   o_lp_data,
   output logic [ZAP_FPAGE_TLB_WDT-1:0]   o_fp_data
);

   section_tlb_t w_se;
   spage_tlb_t   w_sp;
   lpage_tlb_t   w_lp;
   fpage_tlb_t   w_fp;

   // Page entries carry the domain of the L1 descriptor that pointed at them.
   assign w_se = '{tag: i_va[31:20], base: i_desc[31:20], ap: i_desc[11:10], dac: i_desc[8:5], cb: i_desc[3:2]};
   assign w_sp = '{tag: i_va[31:12], base: i_desc[31:12], ap: i_desc[11:4], dac: i_l1_dac, cb: i_desc[3:2]};
   assign w_lp = '{tag: i_va[31:16], base: i_desc[31:16], ap: i_desc[11:4], dac: i_l1_dac, cb: i_desc[3:2]};
   assign w_fp = '{tag: i_va[31:10], base: i_desc[31:10], ap: i_desc[5:4], dac: i_l1_dac, cb: i_desc[3:2]};

   assign o_se_data = w_se;
   assign o_sp_data = w_sp;
   assign o_lp_data = w_lp;
   assign o_fp_data = w_fp;

   always_comb begin
      o_fault     = 1'b0;
      o_status    = 4'd0;
      o_fault_dac = 4'd0;
      o_go_l2     = 1'b0;
      o_l2_fine   = 1'b0;
      o_l2_adr    = 32'd0;
      o_se        = 1'b0;
      o_sp        = 1'b0;
      o_lp        = 1'b0;
      o_fp        = 1'b0;
      if (!i_l2) begin
         case (i_desc[1:0])
            L1_FAULT:   begin o_fault = 1'b1; o_status = FSR_SECT_TRANS; end
            L1_SECTION: o_se = 1'b1;
            L1_COARSE:  begin o_go_l2 = 1'b1; o_l2_adr = {i_desc[31:10], i_va[19:12], 2'b00}; end
            default:    begin
               o_go_l2   = 1'b1;
               o_l2_fine = 1'b1;
               o_l2_adr  = {i_desc[31:12], i_va[19:10], 2'b00};
            end
         endcase
      end else begin
         case (i_desc[1:0])
            L2_LARGE: o_lp = 1'b1;
            L2_SMALL: o_sp = 1'b1;
            L2_TINY:  o_fp = i_fine_tbl;
            default:  o_fp = 1'b0;
         endcase
         if (!(o_lp || o_sp || o_fp)) begin
            o_fault     = 1'b1;
            o_status    = FSR_PAGE_TRANS;
            o_fault_dac = i_l1_dac;
         end
      end
   end

endmodule

// File: rtl/zap_page_walker.sv
// Two-level translation table walker: fetches L1/L2 descriptors over Wishbone,
// then either writes one TLB entry or raises a translation/external abort.
module zap_page_walker
   import zap_page_walker_pkg::*;
(
   input  logic                           i_clk,
   input  logic                           i_reset,
   input  logic                           i_mmu_en,
   input  logic                           i_walk,
   input  logic [31:0]                    i_va,
   input  logic [31:0]                    i_baddr,
   output logic                           o_busy,
   output logic                           o_fault,
   output logic [7:0]                     o_fsr,
   output logic [31:0]                    o_far,
   output logic                           o_wb_cyc,
   output logic                           o_wb_stb,
   output logic [31:0]                    o_wb_adr,
   output logic [3:0]                     o_wb_sel,
   output logic                           o_wb_wen,
   input  logic                           i_wb_ack,
   input  logic                           i_wb_err,
   input  logic [31:0]                    i_wb_dat,
   output logic                           o_setlb_wen,
   output logic                           o_sptlb_wen,
   output logic                           o_lptlb_wen,
   output logic                           o_fptlb_wen,
   output logic [ZAP_SECTION_TLB_WDT-1:0] o_setlb_wdata,
   output logic [ZAP_SPAGE_TLB_WDT-1:0]   o_sptlb_wdata,
   output logic [ZAP_LPAGE_TLB_WDT-1:0]   o_lptlb_wdata,
   output logic [ZAP_FPAGE_TLB_WDT-1:0]   o_fptlb_wdata
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_FETCH_L1  = 3'd1;
   localparam logic [2:0] S_FETCH_L2  = 3'd2;
   localparam logic [2:0] S_WRITE_TLB = 3'd3;
   localparam logic [2:0] S_REFRESH   = 3'd4;

   logic [2:0]  r_state;
   logic [31:0] r_va;
   logic [3:0]  r_dac;
   logic        r_fine;

   logic        w_l2;
   logic        w_fetch;
   logic        w_fault;
   logic [3:0]  w_status;
   logic [3:0]  w_fault_dac;
   logic        w_go_l2;
   logic        w_l2_fine;
   logic [31:0] w_l2_adr;
   logic        w_se, w_sp, w_lp, w_fp;
   logic [ZAP_SECTION_TLB_WDT-1:0] w_se_data;
   logic [ZAP_SPAGE_TLB_WDT-1:0]   w_sp_data;
   logic [ZAP_LPAGE_TLB_WDT-1:0]   w_lp_data;
   logic [ZAP_FPAGE_TLB_WDT-1:0]   w_fp_data;
   logic        w_unused_baddr;

   assign w_l2           = (r_state == S_FETCH_L2);
   assign w_fetch        = (r_state == S_FETCH_L1) || w_l2;
   assign o_busy         = (r_state != S_IDLE);
   assign w_unused_baddr = ^i_baddr[13:0];

   zap_walk_desc_decode u_decode (
      .i_l2        (w_l2),
      .i_fine_tbl  (r_fine),
      .i_desc      (i_wb_dat),
      .i_va        (r_va),
      .i_l1_dac    (r_dac),
      .o_fault     (w_fault),
      .o_status    (w_status),
      .o_fault_dac (w_fault_dac),
      .o_go_l2     (w_go_l2),
      .o_l2_fine   (w_l2_fine),
      .o_l2_adr    (w_l2_adr),
      .o_se        (w_se),
      .o_sp        (w_sp),
      .o_lp        (w_lp),
      .o_fp        (w_fp),
      .o_se_data   (w_se_data),
      .o_sp_data   (w_sp_data),
      .o_lp_data   (w_lp_data),
      .o_fp_data   (w_fp_data)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= S_IDLE;
         o_wb_cyc    <= 1'b0;
         o_wb_stb    <= 1'b0;
         o_wb_adr    <= 32'd0;
         o_wb_sel    <= 4'd0;
         o_wb_wen    <= 1'b0;
         o_fault     <= 1'b0;
         o_fsr       <= 8'd0;
         o_far       <= 32'd0;
         o_setlb_wen <= 1'b0;
         o_sptlb_wen <= 1'b0;
         o_lptlb_wen <= 1'b0;
         o_fptlb_wen <= 1'b0;
      end else begin
         o_fault     <= 1'b0;
         o_setlb_wen <= 1'b0;
         o_sptlb_wen <= 1'b0;
         o_lptlb_wen <= 1'b0;
         o_fptlb_wen <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_walk && i_mmu_en) begin
                  r_state  <= S_FETCH_L1;
                  o_wb_cyc <= 1'b1;
                  o_wb_stb <= 1'b1;
                  o_wb_sel <= 4'hF;
                  o_wb_wen <= 1'b0;
                  o_wb_adr <= {i_baddr[31:14], i_va[31:20], 2'b00};
               end
            end
            S_FETCH_L1, S_FETCH_L2: begin
               // Error takes priority over a simultaneous ack.
               if (i_wb_err || (i_wb_ack && w_fault)) begin
                  r_state  <= S_IDLE;
                  o_wb_cyc <= 1'b0;
                  o_wb_stb <= 1'b0;
                  o_fault  <= 1'b1;
                  o_far    <= r_va;
                  if (i_wb_err)
                     o_fsr <= w_l2 ? {r_dac, FSR_PAGE_EXT} : {4'd0, FSR_SECT_EXT};
                  else
                     o_fsr <= {w_fault_dac, w_status};
               end else if (i_wb_ack && w_go_l2) begin
                  r_state  <= S_FETCH_L2;
                  o_wb_adr <= w_l2_adr;
               end else if (i_wb_ack) begin
                  r_state     <= S_WRITE_TLB;
                  o_wb_cyc    <= 1'b0;
                  o_wb_stb    <= 1'b0;
                  o_setlb_wen <= w_se;
                  o_sptlb_wen <= w_sp;
                  o_lptlb_wen <= w_lp;
                  o_fptlb_wen <= w_fp;
               end
            end
            S_WRITE_TLB: r_state <= S_REFRESH;
            default:     r_state <= S_IDLE;
         endcase
      end
   end

   // Datapath captures: walk context and TLB entry payloads.
   always_ff @(posedge i_clk) begin
      if (r_state == S_IDLE && i_walk && i_mmu_en)
         r_va <= i_va;
      if (r_state == S_FETCH_L1 && i_wb_ack) begin
         r_dac  <= i_wb_dat[8:5];
         r_fine <= w_l2_fine;
      end
      if (w_fetch && i_wb_ack) begin
         o_setlb_wdata <= w_se_data;
         o_sptlb_wdata <= w_sp_data;
         o_lptlb_wdata <= w_lp_data;
         o_fptlb_wdata <= w_fp_data;
      end
   end

endmodule

// File: tb/tb_zap_page_walker.sv
// Scoreboard bench for zap_page_walker: directed walks against a zero-wait
// Wishbone responder, expected TLB writes/aborts queued ahead of each walk.
module tb_zap_page_walker;
   import zap_page_walker_pkg::*;

   logic        clk = 1'b0;
   logic        i_reset, i_mmu_en, i_walk;
   logic [31:0] i_va, i_baddr;
   logic        o_busy, o_fault;
   logic [7:0]  o_fsr;
   logic [31:0] o_far;
   logic        o_wb_cyc, o_wb_stb, o_wb_wen;
   logic [31:0] o_wb_adr;
   logic [3:0]  o_wb_sel;
   logic        i_wb_ack, i_wb_err;
   logic [31:0] i_wb_dat;
   logic        o_setlb_wen, o_sptlb_wen, o_lptlb_wen, o_fptlb_wen;
   logic [ZAP_SECTION_TLB_WDT-1:0] o_setlb_wdata;
   logic [ZAP_SPAGE_TLB_WDT-1:0]   o_sptlb_wdata;
   logic [ZAP_LPAGE_TLB_WDT-1:0]   o_lptlb_wdata;
   logic [ZAP_FPAGE_TLB_WDT-1:0]   o_fptlb_wdata;

   always #5 clk = ~clk;

   zap_page_walker dut (
      .i_clk(clk), .i_reset(i_reset), .i_mmu_en(i_mmu_en), .i_walk(i_walk),
      .i_va(i_va), .i_baddr(i_baddr), .o_busy(o_busy), .o_fault(o_fault),
      .o_fsr(o_fsr), .o_far(o_far), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb),
      .o_wb_adr(o_wb_adr), .o_wb_sel(o_wb_sel), .o_wb_wen(o_wb_wen),
      .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err), .i_wb_dat(i_wb_dat),
      .o_setlb_wen(o_setlb_wen), .o_sptlb_wen(o_sptlb_wen),
      .o_lptlb_wen(o_lptlb_wen), .o_fptlb_wen(o_fptlb_wen),
      .o_setlb_wdata(o_setlb_wdata), .o_sptlb_wdata(o_sptlb_wdata),
      .o_lptlb_wdata(o_lptlb_wdata), .o_fptlb_wdata(o_fptlb_wdata)
   );

   localparam logic [4:0] K_SE  = 5'b00001;
   localparam logic [4:0] K_SP  = 5'b00010;
   localparam logic [4:0] K_LP  = 5'b00100;
   localparam logic [4:0] K_FP  = 5'b01000;
   localparam logic [4:0] K_FLT = 5'b10000;

   typedef struct {
      logic [4:0]  kind;
      logic [63:0] data;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic push(input logic [4:0] kind, input logic [63:0] data);
      exp_t e;
      e.kind = kind;
      e.data = data;
      sb.push_back(e);
   endtask

   // Monitor: every TLB write or abort must match the oldest queued expectation.
   logic [4:0]  m_kind;
   logic [63:0] m_data;
   exp_t        m_exp;
   always @(negedge clk) begin
      m_kind = {o_fault, o_fptlb_wen, o_lptlb_wen, o_sptlb_wen, o_setlb_wen};
      if (m_kind != 5'd0) begin
         if (sb.size() == 0) begin
            chk("unexpected_event", 64'(m_kind), 64'd0);
         end else begin
            m_exp = sb.pop_front();
            chk("event_kind", 64'(m_kind), 64'(m_exp.kind));
            case (m_exp.kind)
               K_SE:    m_data = 64'(o_setlb_wdata);
               K_SP:    m_data = 64'(o_sptlb_wdata);
               K_LP:    m_data = 64'(o_lptlb_wdata);
               K_FP:    m_data = 64'(o_fptlb_wdata);
               default: m_data = {24'd0, o_fsr, o_far};
            endcase
            chk("event_data", m_data, m_exp.data);
         end
      end
   end

   // Zero-wait slave: acks (or errs) every strobe in the cycle it is seen.
   task automatic walk(input logic [31:0] va, input int n,
                       input logic [31:0] a0, input logic [31:0] d0, input logic e0,
                       input logic [31:0] a1, input logic [31:0] d1, input logic e1,
                       input logic both0, input logic drop_en, input int exp_busy);
      int k;
      int busy_cnt;
      @(negedge clk);
      i_va   = va;
      i_walk = 1'b1;
      @(negedge clk);
      i_walk = 1'b0;
      if (drop_en) i_mmu_en = 1'b0;
      k = 0;
      busy_cnt = 0;
      for (int c = 0; c < 40; c++) begin
         i_wb_ack = 1'b0;
         i_wb_err = 1'b0;
         if (o_wb_cyc && o_wb_stb && k < n) begin
            chk("bus_adr", 64'(o_wb_adr), 64'((k == 0) ? a0 : a1));
            chk("bus_sel_wen", 64'({o_wb_sel, o_wb_wen}), 64'h1E);
            i_wb_dat = (k == 0) ? d0 : d1;
            i_wb_err = (k == 0) ? e0 : e1;
            i_wb_ack = !i_wb_err || (k == 0 && both0);
            k++;
         end
         if (!o_busy) break;
         busy_cnt++;
         @(negedge clk);
      end
      i_wb_ack = 1'b0;
      i_wb_err = 1'b0;
      i_mmu_en = 1'b1;
      chk("walk_done", 64'({o_busy, o_wb_cyc, o_wb_stb}), 64'd0);
      chk("busy_cycles", 64'(busy_cnt), 64'(exp_busy));
      @(negedge clk);
      #1 chk("scoreboard_drained", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      i_reset  = 1'b1;
      i_mmu_en = 1'b1;
      i_walk   = 1'b0;
      i_va     = 32'd0;
      i_baddr  = 32'h0000_4000;
      i_wb_ack = 1'b0;
      i_wb_err = 1'b0;
      i_wb_dat = 32'd0;
      repeat (3) @(negedge clk);
      i_reset = 1'b0;
      chk("rst_bus", 64'({o_wb_cyc, o_wb_stb, o_wb_wen, o_wb_sel}), 64'd0);
      chk("rst_adr", 64'(o_wb_adr), 64'd0);
      chk("rst_busy_fault", 64'({o_busy, o_fault}), 64'd0);
      chk("rst_wens", 64'({o_setlb_wen, o_sptlb_wen, o_lptlb_wen, o_fptlb_wen}), 64'd0);
      chk("rst_fsr_far", {24'd0, o_fsr, o_far}, 64'd0);

      // Section
      push(K_SE, 64'h1238_76C3);
      walk(32'h1234_5678, 1, 32'h0000_448C, 32'h8760_0C0E, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 3);
      // Coarse table, small page
      push(K_SP, 64'({20'h00045, 20'hABCDE, 8'hFF, 4'h0, 2'b11}));
      walk(32'h0004_5000, 2, 32'h0000_4000, 32'h0010_0001, 1'b0, 32'h0010_0114, 32'hABCD_EFFE, 1'b0, 1'b0, 1'b0, 4);
      // L1 translation fault
      push(K_FLT, {24'd0, 8'h05, 32'h1234_5678});
      walk(32'h1234_5678, 1, 32'h0000_448C, 32'h0000_0000, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1);
      // L2 bus error, L1 domain 5
      push(K_FLT, {24'd0, 8'h5E, 32'h0004_5000});
      walk(32'h0004_5000, 2, 32'h0000_4000, 32'h0010_00A1, 1'b0, 32'h0010_0114, 32'h0, 1'b1, 1'b0, 1'b0, 2);
      // Coarse table, large page, domain 2
      push(K_LP, 64'({16'h7654, 16'h5555, 8'hA7, 4'h2, 2'b01}));
      walk(32'h7654_3000, 2, 32'h0000_5D94, 32'h0030_0041, 1'b0, 32'h0030_010C, 32'h5555_0A75, 1'b0, 1'b0, 1'b0, 4);
      // Fine table, tiny page, domain B
      push(K_FP, 64'({22'h000203, 22'h048D17, 2'b11, 4'hB, 2'b01}));
      walk(32'h0008_0C00, 2, 32'h0000_4000, 32'h0020_0163, 1'b0, 32'h0020_080C, 32'h1234_5C37, 1'b0, 1'b0, 1'b0, 4);
      // Tiny page descriptor under a coarse table is a page fault
      push(K_FLT, {24'd0, 8'h27, 32'h7654_3000});
      walk(32'h7654_3000, 2, 32'h0000_5D94, 32'h0030_0041, 1'b0, 32'h0030_010C, 32'h5555_0A77, 1'b0, 1'b0, 1'b0, 2);
      // Invalid L2 descriptor under a fine table
      push(K_FLT, {24'd0, 8'hB7, 32'h0008_0C00});
      walk(32'h0008_0C00, 2, 32'h0000_4000, 32'h0020_0163, 1'b0, 32'h0020_080C, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 2);
      // L1 bus error
      push(K_FLT, {24'd0, 8'h0C, 32'h1234_5678});
      walk(32'h1234_5678, 1, 32'h0000_448C, 32'h8760_0C0E, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1);
      // Ack and err together on L1: the error is reported
      push(K_FLT, {24'd0, 8'h0C, 32'hFFF0_0000});
      walk(32'hFFF0_0000, 1, 32'h0000_7FFC, 32'h8760_0C0E, 1'b1, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1);

      // Walk request ignored while the MMU is off
      @(negedge clk);
      i_mmu_en = 1'b0;
      i_walk   = 1'b1;
      repeat (3) @(negedge clk);
      chk("mmu_off_idle", 64'({o_busy, o_wb_cyc}), 64'd0);
      i_walk   = 1'b0;
      i_mmu_en = 1'b1;

      // MMU disabled mid-walk still completes; abort registers stay untouched
      push(K_SE, 64'({12'hABC, 12'hFED, 2'b10, 4'hB, 2'b00}));
      walk(32'hABC0_0000, 1, 32'h0000_6AF0, 32'hFED0_0962, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 3);
      chk("fsr_far_held", {24'd0, o_fsr, o_far}, {24'd0, 8'h0C, 32'hFFF0_0000});

      // Reset while the L2 fetch is outstanding; the late ack must be ignored
      @(negedge clk);
      i_va   = 32'h0004_5000;
      i_walk = 1'b1;
      @(negedge clk);
      i_walk   = 1'b0;
      i_wb_dat = 32'h0010_0001;
      i_wb_ack = 1'b1;
      @(negedge clk);
      i_wb_ack = 1'b0;
      chk("l2_outstanding", 64'({o_wb_cyc, o_wb_stb, o_busy}), 64'h7);
      i_reset = 1'b1;
      @(negedge clk);
      i_reset  = 1'b0;
      chk("rst_drops_cyc", 64'({o_wb_cyc, o_wb_stb, o_busy}), 64'd0);
      i_wb_dat = 32'hABCD_EFFE;
      i_wb_ack = 1'b1;
      @(negedge clk);
      i_wb_ack = 1'b0;
      repeat (2) @(negedge clk);
      chk("late_ack_ignored", 64'({o_wb_cyc, o_busy, o_fault}), 64'd0);
      chk("fsr_after_reset", 64'(o_fsr), 64'd0);
      #1 chk("scoreboard_final", 64'(sb.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
